// File: rtl/car_warning_ctrl.sv
// -----------------------------------------------------------------------------
// car_warning_ctrl
//   Car warning controller for NUM_DOORS door sensors and NUM_SEATS seat
//   occupancy/belt pairs. Every raw input is debounced, faults are qualified
//   with the debounced ignition, and an active fault escalates from a silent
//   grace period to a blinking chime and then to a solid alarm. A driver
//   acknowledge mutes the alarm until the fault clears.
//
// Ports
//   Clk           in   system clock, rising edge
//   nRst          in   asynchronous active-low reset
//   Ignition      in   1 = ignition on
//   DoorClose     in   [NUM_DOORS]  1 = door closed
//   SeatOccupied  in   [NUM_SEATS]  1 = seat occupied
//   SeatBelt      in   [NUM_SEATS]  1 = belt fastened
//   Ack           in   driver acknowledge, level sampled every clock
//   Alarm         out  buzzer drive (registered)
//   Lamp          out  registered fault indicator
//   DoorOpenMask  out  [NUM_DOORS] registered open doors while ignition on
//   BeltMissMask  out  [NUM_SEATS] registered occupied-but-unbelted seats
//   State         out  [3] registered FSM state code
// -----------------------------------------------------------------------------
module car_warning_ctrl #(
  parameter int NUM_DOORS   = 4,
  parameter int NUM_SEATS   = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int TICK_DIV    = 1000,
  parameter int GRACE_TICKS = 3,
  parameter int CHIME_TICKS = 8,
  parameter int BLINK_TICKS = 2
) (
  input  logic                 Clk,
  input  logic                 nRst,
  input  logic                 Ignition,
  input  logic [NUM_DOORS-1:0] DoorClose,
  input  logic [NUM_SEATS-1:0] SeatOccupied,
  input  logic [NUM_SEATS-1:0] SeatBelt,
  input  logic                 Ack,
  output logic                 Alarm,
  output logic                 Lamp,
  output logic [NUM_DOORS-1:0] DoorOpenMask,
  output logic [NUM_SEATS-1:0] BeltMissMask,
  output logic [2:0]           State
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRACE    = 3'd1,
    S_CHIME    = 3'd2,
    S_ESCALATE = 3'd3,
    S_MUTED    = 3'd4
  } state_e;

  localparam int NB      = NUM_DOORS + 2 * NUM_SEATS + 1;
  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMR_MAX = (GRACE_TICKS > CHIME_TICKS) ? GRACE_TICKS : CHIME_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_TICKS + 1);

  // Debounced reset image: doors closed, belts fastened, seats empty, ignition off.
  localparam logic [NB-1:0] DB_RST = {1'b0, {NUM_SEATS{1'b1}}, {NUM_SEATS{1'b0}},
                                      {NUM_DOORS{1'b1}}};

  logic [NB-1:0]             raw;
  logic [NB-1:0]             db_q, db_d;
  logic [NB-1:0][DEB_W-1:0]  cnt_q, cnt_d;

  logic [PRE_W-1:0]          pre_q, pre_d;
  logic                      tick;

  logic [NUM_DOORS-1:0]      door_db, door_mask_q, door_mask_d;
  logic [NUM_SEATS-1:0]      occ_db, belt_db, belt_mask_q, belt_mask_d;
  logic                      ign_db;
  logic                      lamp_q, lamp_d;

  state_e                    state_q, state_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [BLK_W-1:0]          blink_q, blink_d;
  logic                      alarm_q, alarm_d;

  assign raw = {Ignition, SeatBelt, SeatOccupied, DoorClose};

  // Per-bit debounce: the copy follows raw once raw has differed on DEB_CYCLES
  // consecutive clocks; any agreement restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (raw[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
        db_d[i]  = raw[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign door_db = db_q[NUM_DOORS-1:0];
  assign occ_db  = db_q[NUM_DOORS +: NUM_SEATS];
  assign belt_db = db_q[NUM_DOORS + NUM_SEATS +: NUM_SEATS];
  assign ign_db  = db_q[NB-1];

  assign door_mask_d = {NUM_DOORS{ign_db}} & ~door_db;
  assign belt_mask_d = {NUM_SEATS{ign_db}} & occ_db & ~belt_db;
  assign lamp_d      = (|door_mask_d) | (|belt_mask_d);

  // Free-running prescaler; FSM activity never touches it.
  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // The FSM acts on the registered fault (Lamp), so it trails the lamp by one clock.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    blink_d = blink_q;
    alarm_d = alarm_q;
    if ((state_q != S_IDLE) && !lamp_q) begin
      state_d = S_IDLE;
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          alarm_d = 1'b0;
          if (lamp_q) begin
            state_d = S_GRACE;
            timer_d = TMR_W'(GRACE_TICKS);
          end
        end
        S_GRACE: begin
          alarm_d = 1'b0;
          if (tick) begin
            if (timer_q == TMR_W'(1)) begin
              state_d = S_CHIME;
              timer_d = TMR_W'(CHIME_TICKS);
              blink_d = BLK_W'(BLINK_TICKS);
              alarm_d = 1'b1;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end
        S_CHIME: begin
          if (Ack) begin
            state_d = S_MUTED;
            alarm_d = 1'b0;
          end else if (tick) begin
            if (timer_q == TMR_W'(1)) begin
              state_d = S_ESCALATE;
              alarm_d = 1'b1;
            end else begin
              timer_d = timer_q - 1'b1;
              if (blink_q == BLK_W'(1)) begin
                alarm_d = ~alarm_q;
                blink_d = BLK_W'(BLINK_TICKS);
              end else begin
                blink_d = blink_q - 1'b1;
              end
            end
          end
        end
        S_ESCALATE: begin
          if (Ack) begin
            state_d = S_MUTED;
            alarm_d = 1'b0;
          end else begin
            alarm_d = 1'b1;
          end
        end
        S_MUTED: begin
          alarm_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          alarm_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      db_q        <= DB_RST;
      cnt_q       <= '0;
      pre_q       <= '0;
      door_mask_q <= '0;
      belt_mask_q <= '0;
      lamp_q      <= 1'b0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      blink_q     <= '0;
      alarm_q     <= 1'b0;
    end else begin
      db_q        <= db_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      door_mask_q <= door_mask_d;
      belt_mask_q <= belt_mask_d;
      lamp_q      <= lamp_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      blink_q     <= blink_d;
      alarm_q     <= alarm_d;
    end
  end

  assign Alarm        = alarm_q;
  assign Lamp         = lamp_q;
  assign DoorOpenMask = door_mask_q;
  assign BeltMissMask = belt_mask_q;
  assign State        = state_q;

endmodule

// File: tb/tb_car_warning_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_warning_ctrl
//   Directed scenarios followed by randomized input segments. A behavioural
//   model tracks debounced inputs as "last DEB samples all disagree", and the
//   warning sequence as elapsed ticks since state entry; every clock the DUT
//   outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_car_warning_ctrl;
  localparam int ND  = 4;
  localparam int NS  = 2;
  localparam int DEB = 4;
  localparam int GR  = 3;
  localparam int CH  = 8;
  localparam int BL  = 2;
  localparam int NB  = ND + 2 * NS + 1;

  localparam int S_IDLE = 0, S_GRACE = 1, S_CHIME = 2, S_ESC = 3, S_MUTED = 4;

  logic          Clk = 1'b0;
  logic          nRst = 1'b0;
  logic          Ignition = 1'b0;
  logic [ND-1:0] DoorClose = '1;
  logic [NS-1:0] SeatOccupied = '0;
  logic [NS-1:0] SeatBelt = '1;
  logic          Ack = 1'b0;
  logic          Alarm, Lamp;
  logic [ND-1:0] DoorOpenMask;
  logic [NS-1:0] BeltMissMask;
  logic [2:0]    State;

  car_warning_ctrl #(
    .NUM_DOORS(ND), .NUM_SEATS(NS), .DEB_CYCLES(DEB), .TICK_DIV(1),
    .GRACE_TICKS(GR), .CHIME_TICKS(CH), .BLINK_TICKS(BL)
  ) dut (
    .Clk(Clk), .nRst(nRst), .Ignition(Ignition), .DoorClose(DoorClose),
    .SeatOccupied(SeatOccupied), .SeatBelt(SeatBelt), .Ack(Ack),
    .Alarm(Alarm), .Lamp(Lamp), .DoorOpenMask(DoorOpenMask),
    .BeltMissMask(BeltMissMask), .State(State)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_state;
  int            m_k;        // ticks elapsed since entering m_state
  logic          m_lamp;
  logic [ND-1:0] m_dmask;
  logic [NS-1:0] m_bmask;
  logic [NB-1:0] m_db;       // {ign, belt, occ, door}
  logic [NB-1:0] hist[$];    // most recent raw samples, oldest first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_alarm(input int st, input int k);
    if (st == S_ESC)   return 1'b1;
    if (st == S_CHIME) return ((k / BL) % 2) == 0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_k     = 0;
    m_lamp  = 1'b0;
    m_dmask = '0;
    m_bmask = '0;
    m_db    = {1'b0, {NS{1'b1}}, {NS{1'b0}}, {ND{1'b1}}};
    hist.delete();
  endtask

  task automatic model_edge();
    logic          ign;
    logic [ND-1:0] dc;
    logic [NS-1:0] occ, belt;
    logic [NB-1:0] ndb;
    logic [ND-1:0] ndm;
    logic [NS-1:0] nbm;
    bit            all_diff;
    ign  = m_db[NB-1];
    dc   = m_db[ND-1:0];
    occ  = m_db[ND +: NS];
    belt = m_db[ND+NS +: NS];
    ndm  = ign ? ~dc : '0;
    nbm  = ign ? (occ & ~belt) : '0;
    // warning sequence uses the lamp value from before this edge
    if (m_state != S_IDLE && !m_lamp) begin
      m_state = S_IDLE; m_k = 0;
    end else begin
      case (m_state)
        S_IDLE:  if (m_lamp) begin m_state = S_GRACE; m_k = 0; end
        S_GRACE: if (m_k + 1 == GR) begin m_state = S_CHIME; m_k = 0; end else m_k++;
        S_CHIME: begin
          if (Ack) begin m_state = S_MUTED; m_k = 0; end
          else if (m_k + 1 == CH) begin m_state = S_ESC; m_k = 0; end
          else m_k++;
        end
        S_ESC:   if (Ack) begin m_state = S_MUTED; m_k = 0; end
        default: ;
      endcase
    end
    hist.push_back({Ignition, SeatBelt, SeatOccupied, DoorClose});
    if (hist.size() > DEB) void'(hist.pop_front());
    ndb = m_db;
    if (hist.size() == DEB) begin
      for (int b = 0; b < NB; b++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) ndb[b] = ~m_db[b];
      end
    end
    m_dmask = ndm;
    m_bmask = nbm;
    m_lamp  = (ndm != '0) || (nbm != '0);
    m_db    = ndb;
  endtask

  task automatic check_all();
    chk("state", 32'(State), 32'(m_state));
    chk("alarm", 32'(Alarm), 32'(model_alarm(m_state, m_k)));
    chk("lamp", 32'(Lamp), 32'(m_lamp));
    chk("door_mask", 32'(DoorOpenMask), 32'(m_dmask));
    chk("belt_mask", 32'(BeltMissMask), 32'(m_bmask));
  endtask

  task automatic step();
    @(posedge Clk);
    if (nRst) model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Called 1 time unit after an edge; reset pulse lies entirely between edges.
  task automatic async_reset_pulse();
    #3 nRst = 1'b0;
    #1;
    chk("rst_alarm", 32'(Alarm), 32'd0);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_lamp", 32'(Lamp), 32'd0);
    model_reset();
    #1 nRst = 1'b1;
  endtask

  initial begin
    logic [7:0] chime_pat;
    bit         found;
    chime_pat = 8'b0011_0011;
    model_reset();

    // Power-on reset held over two edges
    repeat (2) @(posedge Clk);
    #1;
    chk("por_state", 32'(State), 32'd0);
    chk("por_alarm", 32'(Alarm), 32'd0);
    chk("por_lamp", 32'(Lamp), 32'd0);
    chk("por_dmask", 32'(DoorOpenMask), 32'd0);
    chk("por_bmask", 32'(BeltMissMask), 32'd0);
    #2 nRst = 1'b1;
    run(3);

    // Ignition on with door 0 open: full escalation timeline
    Ignition = 1'b1; DoorClose = 4'b1110;
    run(4);
    chk("t1_dmask_e3", 32'(DoorOpenMask), 32'd0);
    step();
    chk("t1_dmask_e4", 32'(DoorOpenMask), 32'b0001);
    chk("t1_lamp_e4", 32'(Lamp), 32'd1);
    step();
    chk("t1_grace_e5", 32'(State), 32'(S_GRACE));
    run(2);
    for (int e = 0; e < 8; e++) begin
      step();
      chk("t1_chime_state", 32'(State), 32'(S_CHIME));
      chk("t1_chime_alarm", 32'(Alarm), 32'(chime_pat[e]));
    end
    step();
    chk("t1_esc_state", 32'(State), 32'(S_ESC));
    chk("t1_esc_alarm", 32'(Alarm), 32'd1);
    run(3);
    chk("t1_esc_hold", 32'(Alarm), 32'd1);

    // Asynchronous reset mid-escalation, fault still present afterwards
    async_reset_pulse();
    run(5);
    step();
    chk("t5_regrace", 32'(State), 32'(S_GRACE));
    Ignition = 1'b0; DoorClose = 4'b1111;
    run(8);

    // Three-clock glitch on door 2 never reaches the outputs
    Ignition = 1'b1;
    run(6);
    DoorClose = 4'b1011;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) DoorClose = 4'b1111;
      step();
      chk("t2_dmask", 32'(DoorOpenMask), 32'd0);
      chk("t2_state", 32'(State), 32'(S_IDLE));
    end

    // Seat 1 occupied without belt, then fastened while chiming
    SeatOccupied = 2'b10; SeatBelt = 2'b00;
    run(4);
    step();
    chk("t3_bmask", 32'(BeltMissMask), 32'b10);
    run(4);
    SeatBelt = 2'b11;
    run(6);
    chk("t3_idle_state", 32'(State), 32'(S_IDLE));
    chk("t3_idle_alarm", 32'(Alarm), 32'd0);
    SeatOccupied = 2'b00;
    run(6);

    // Ack while chiming mutes; a further open door does not re-arm
    DoorClose = 4'b1110;
    run(10);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("t4_muted", 32'(State), 32'(S_MUTED));
    chk("t4_mute_alarm", 32'(Alarm), 32'd0);
    DoorClose = 4'b1100;
    run(8);
    chk("t4_still_muted", 32'(State), 32'(S_MUTED));
    DoorClose = 4'b1111;
    run(6);
    chk("t4_idle", 32'(State), 32'(S_IDLE));

    // Fault clears on the same edge as Ack and CHIME expiry
    DoorClose = 4'b1110;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_state == S_CHIME && m_k == CH - 6) found = 1'b1;
    end
    chk("t6_reach_chime", 32'(found), 32'd1);
    DoorClose = 4'b1111;
    run(5);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("t6_idle", 32'(State), 32'(S_IDLE));
    chk("t6_alarm", 32'(Alarm), 32'd0);
    run(3);
    chk("t6_stay_idle", 32'(State), 32'(S_IDLE));

    // Randomized segments of held inputs with sporadic Ack and resets
    for (int s = 0; s < 150; s++) begin
      int dur;
      Ignition = ($urandom_range(0, 3) != 0);
      DoorClose = '1;
      if ($urandom_range(0, 2) == 0) DoorClose[$urandom_range(0, ND - 1)] = 1'b0;
      SeatOccupied = NS'($urandom);
      SeatBelt     = NS'($urandom);
      dur = $urandom_range(1, 20);
      for (int c = 0; c < dur; c++) begin
        Ack = ($urandom_range(0, 15) == 0);
        step();
      end
      Ack = 1'b0;
      if ($urandom_range(0, 49) == 0) async_reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
